// File: rtl/riscv_cache_biu_arb.sv
// Cache line-fill / non-cacheable read arbiter in front of the BIU, with outstanding-transfer tracking.
// Define RISCV_CACHE_ARB_CWF_EN for critical-word-first fills; by default fills start line-aligned.
module riscv_cache_biu_arb #(
    parameter  int XLEN           = 32,
    parameter  int PLEN           = XLEN,
    parameter  int BLK_BITS       = 128,
    parameter  int INFLIGHT_DEPTH = 2,
    localparam int BURST_SIZE     = BLK_BITS / XLEN,
    localparam int INFLIGHT_BITS  = $clog2(INFLIGHT_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fill_req_i,
    input  logic [PLEN-1:0]          fill_adr_i,
    output logic                     fill_ack_o,
    output logic                     fill_err_o,
    input  logic                     nc_req_i,
    input  logic [PLEN-1:0]          nc_adr_i,
    output logic                     nc_stb_ack_o,
    output logic                     nc_ack_o,
    input  logic                     flush_i,
    output logic                     biu_stb_o,
    input  logic                     biu_stb_ack_i,
    output logic [PLEN-1:0]          biu_adri_o,
    output logic                     biu_burst_o,
    input  logic                     biu_ack_i,
    input  logic                     biu_err_i,
    input  logic [XLEN-1:0]          biu_q_i,
    output logic [BLK_BITS-1:0]      line_o,
    output logic [BURST_SIZE-1:0]    word_vld_o,
    output logic [INFLIGHT_BITS-1:0] inflight_cnt_o
);

    localparam int BURST_BITS = $clog2(BURST_SIZE);
    localparam int BYTE_BITS  = $clog2(XLEN / 8);
    localparam int LINE_BITS  = BYTE_BITS + BURST_BITS;
    localparam logic [INFLIGHT_BITS-1:0] MAX_INFLIGHT = INFLIGHT_BITS'(INFLIGHT_DEPTH);
    localparam logic [BURST_BITS-1:0]    LAST_BEAT    = BURST_BITS'(BURST_SIZE - 1);
    localparam logic [PLEN-1:0]          BYTE_MASK    = PLEN'((1 << BYTE_BITS) - 1);
    localparam logic [PLEN-1:0]          LINE_MASK    = PLEN'((1 << LINE_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL_REQ,
        FILL_DATA,
        FILL_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [INFLIGHT_BITS-1:0] r_inflight;
    logic [INFLIGHT_BITS-1:0] r_discard;
    logic [INFLIGHT_BITS-1:0] w_inflight_nxt;
    logic [BURST_BITS-1:0]    r_widx;
    logic [BURST_BITS-1:0]    r_beat;
    logic [BURST_BITS-1:0]    w_start_widx;
    logic [PLEN-1:0]          r_fill_adr;
    logic [PLEN-1:0]          w_start_adr;
    logic [BLK_BITS-1:0]      r_line;
    logic [BURST_SIZE-1:0]    r_word_vld;
    logic                     r_fill_err;
    logic                     w_stb_accept;
    logic                     w_rsp;
    logic                     w_fill_start;

`ifdef RISCV_CACHE_ARB_CWF_EN
    assign w_start_adr  = fill_adr_i & ~BYTE_MASK;
    assign w_start_widx = fill_adr_i[LINE_BITS-1:BYTE_BITS];
`else
    assign w_start_adr  = fill_adr_i & ~LINE_MASK;
    assign w_start_widx = '0;
`endif

    assign w_stb_accept = biu_stb_o & biu_stb_ack_i;
    assign w_rsp        = biu_ack_i | biu_err_i;
    assign w_fill_start = (r_state == IDLE) && (w_state_nxt == FILL_REQ);

    // Burst beats also count as responses, so the counter saturates at both ends.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_stb_accept && !w_rsp && (r_inflight != MAX_INFLIGHT))
            w_inflight_nxt = r_inflight + INFLIGHT_BITS'(1);
        else if (!w_stb_accept && w_rsp && (r_inflight != '0))
            w_inflight_nxt = r_inflight - INFLIGHT_BITS'(1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        biu_stb_o    = 1'b0;
        biu_burst_o  = 1'b0;
        biu_adri_o   = '0;
        nc_stb_ack_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (fill_req_i) begin
                    if (r_inflight == '0)
                        w_state_nxt = FILL_REQ;
                end else if (nc_req_i && (r_inflight != MAX_INFLIGHT)) begin
                    biu_stb_o    = 1'b1;
                    biu_adri_o   = nc_adr_i & ~BYTE_MASK;
                    nc_stb_ack_o = biu_stb_ack_i;
                end
            end
            FILL_REQ: begin
                biu_stb_o   = 1'b1;
                biu_burst_o = 1'b1;
                biu_adri_o  = r_fill_adr;
                if (biu_err_i)
                    w_state_nxt = IDLE;
                else if (biu_stb_ack_i)
                    w_state_nxt = FILL_DATA;
            end
            FILL_DATA: begin
                if (biu_err_i)
                    w_state_nxt = IDLE;
                else if (biu_ack_i && (r_beat == LAST_BEAT))
                    w_state_nxt = FILL_DONE;
            end
            FILL_DONE: w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
        // The state register may still hold a busy state until the reset edge.
        if (rst_i) begin
            biu_stb_o    = 1'b0;
            nc_stb_ack_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_inflight <= '0;
            r_discard  <= '0;
            r_widx     <= '0;
            r_beat     <= '0;
            r_fill_adr <= '0;
            r_line     <= '0;
            r_word_vld <= '0;
            r_fill_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            r_fill_err <= biu_err_i && ((r_state == FILL_REQ) || (r_state == FILL_DATA));
            if (flush_i)
                r_discard <= w_inflight_nxt;
            else if (w_rsp && (r_discard != '0))
                r_discard <= r_discard - INFLIGHT_BITS'(1);
            if (w_fill_start) begin
                r_fill_adr <= w_start_adr;
                r_widx     <= w_start_widx;
                r_beat     <= '0;
                r_word_vld <= '0;
            end else if ((r_state == FILL_DATA) && biu_ack_i && !biu_err_i) begin
                for (int w = 0; w < BURST_SIZE; w++) begin
                    if (r_widx == BURST_BITS'(w)) begin
                        r_line[w*XLEN +: XLEN] <= biu_q_i;
                        r_word_vld[w]          <= 1'b1;
                    end
                end
                r_widx <= r_widx + BURST_BITS'(1);
                r_beat <= r_beat + BURST_BITS'(1);
            end
        end
    end

    assign fill_ack_o     = (r_state == FILL_DONE);
    assign fill_err_o     = r_fill_err;
    assign nc_ack_o       = biu_ack_i && (r_state == IDLE) && (r_discard == '0) && !rst_i;
    assign line_o         = r_line;
    assign word_vld_o     = r_word_vld;
    assign inflight_cnt_o = r_inflight;

endmodule

// File: tb/tb_riscv_cache_biu_arb.sv
// Directed bench for riscv_cache_biu_arb; expectations follow RISCV_CACHE_ARB_CWF_EN when defined.
module tb_riscv_cache_biu_arb;

    localparam logic [31:0] WA = 32'hAAAA0001;
    localparam logic [31:0] WB = 32'hBBBB0002;
    localparam logic [31:0] WC = 32'hCCCC0003;
    localparam logic [31:0] WD = 32'hDDDD0004;
    localparam logic [31:0] WP = 32'h11110010;
    localparam logic [31:0] WQ = 32'h22220020;
    localparam logic [31:0] WR = 32'h33330030;
    localparam logic [31:0] WS = 32'h44440040;
    localparam logic [31:0] T0 = 32'h5A5A0100;
    localparam logic [31:0] T1 = 32'h5A5A0101;
    localparam logic [31:0] T2 = 32'h5A5A0102;
    localparam logic [31:0] T3 = 32'h5A5A0103;

`ifdef RISCV_CACHE_ARB_CWF_EN
    localparam logic [31:0]  EXP_ADR_1008 = 32'h1008;
    localparam logic [127:0] EXP_LINE_1   = {WB, WA, WD, WC};
    localparam logic [3:0]   EXP_VLD_ERR  = 4'b0100;
    localparam logic [31:0]  EXP_ADR_4004 = 32'h4004;
    localparam logic [127:0] EXP_LINE_5   = {T2, T1, T0, T3};
`else
    localparam logic [31:0]  EXP_ADR_1008 = 32'h1000;
    localparam logic [127:0] EXP_LINE_1   = {WD, WC, WB, WA};
    localparam logic [3:0]   EXP_VLD_ERR  = 4'b0001;
    localparam logic [31:0]  EXP_ADR_4004 = 32'h4000;
    localparam logic [127:0] EXP_LINE_5   = {T3, T2, T1, T0};
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         fill_req_i = 1'b0;
    logic [31:0]  fill_adr_i = '0;
    logic         fill_ack_o;
    logic         fill_err_o;
    logic         nc_req_i = 1'b0;
    logic [31:0]  nc_adr_i = '0;
    logic         nc_stb_ack_o;
    logic         nc_ack_o;
    logic         flush_i = 1'b0;
    logic         biu_stb_o;
    logic         biu_stb_ack_i = 1'b0;
    logic [31:0]  biu_adri_o;
    logic         biu_burst_o;
    logic         biu_ack_i = 1'b0;
    logic         biu_err_i = 1'b0;
    logic [31:0]  biu_q_i = '0;
    logic [127:0] line_o;
    logic [3:0]   word_vld_o;
    logic [1:0]   inflight_cnt_o;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk_i = ~clk_i;

    riscv_cache_biu_arb #(
        .XLEN(32), .PLEN(32), .BLK_BITS(128), .INFLIGHT_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fill_req_i(fill_req_i), .fill_adr_i(fill_adr_i),
        .fill_ack_o(fill_ack_o), .fill_err_o(fill_err_o),
        .nc_req_i(nc_req_i), .nc_adr_i(nc_adr_i),
        .nc_stb_ack_o(nc_stb_ack_o), .nc_ack_o(nc_ack_o),
        .flush_i(flush_i),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_adri_o(biu_adri_o), .biu_burst_o(biu_burst_o),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i), .biu_q_i(biu_q_i),
        .line_o(line_o), .word_vld_o(word_vld_o), .inflight_cnt_o(inflight_cnt_o)
    );

    // Each call starts a new cycle: inputs change 1ns after the edge, outputs are checked 1ns later.
    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic nr,
                                 input logic [31:0] na, input logic fl, input logic sa,
                                 input logic ak, input logic er, input logic [31:0] q);
        @(posedge clk_i);
        #1;
        fill_req_i    = fr;
        fill_adr_i    = fa;
        nc_req_i      = nr;
        nc_adr_i      = na;
        flush_i       = fl;
        biu_stb_ack_i = sa;
        biu_ack_i     = ak;
        biu_err_i     = er;
        biu_q_i       = q;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // One complete fill starting from IDLE with inflight=0, immediate stb_ack and back-to-back beats.
    task automatic runFill(input string tag, input logic [31:0] adr, input logic [31:0] expAdr,
                           input logic [127:0] beats, input logic [127:0] expLine,
                           input logic ncHold);
        applyStimulus(1'b1, adr, ncHold, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_idle_stb"}, biu_stb_o, 1'b0);
        checkOutput({tag, "_idle_ncstbak"}, nc_stb_ack_o, 1'b0);
        applyStimulus(1'b1, adr, ncHold, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_req_stb"}, biu_stb_o, 1'b1);
        checkOutput({tag, "_req_burst"}, biu_burst_o, 1'b1);
        checkOutput({tag, "_req_adr"}, biu_adri_o, expAdr);
        checkOutput({tag, "_req_ncstbak"}, nc_stb_ack_o, 1'b0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b0, adr, ncHold, 32'h6000, (b == 1), 1'b0, 1'b1, 1'b0, beats[b*32 +: 32]);
            checkOutput({tag, "_beat_ack"}, fill_ack_o, 1'b0);
            checkOutput({tag, "_beat_stb"}, biu_stb_o, 1'b0);
        end
        applyStimulus(1'b0, adr, ncHold, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_done_ack"}, fill_ack_o, 1'b1);
        checkOutput({tag, "_done_ncstbak"}, nc_stb_ack_o, 1'b0);
        checkOutput({tag, "_done_line"}, line_o, expLine);
        checkOutput({tag, "_done_vld"}, word_vld_o, 4'hF);
        checkOutput({tag, "_done_inflight"}, inflight_cnt_o, 2'd0);
        applyStimulus(1'b0, adr, ncHold, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_after_ack"}, fill_ack_o, 1'b0);
        checkOutput({tag, "_after_line"}, line_o, expLine);
    endtask

    initial begin
        // Reset with live requests: strobes and acks must stay quiet.
        rst_i = 1'b1;
        applyStimulus(1'b1, 32'h1008, 1'b1, 32'h2006, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_stb", biu_stb_o, 1'b0);
        checkOutput("rst_ncstbak", nc_stb_ack_o, 1'b0);
        checkOutput("rst_ncack", nc_ack_o, 1'b0);
        checkOutput("rst_inflight", inflight_cnt_o, 2'd0);
        checkOutput("rst_vld", word_vld_o, 4'h0);
        checkOutput("rst_line", line_o, 128'h0);
        checkOutput("rst_fillack", fill_ack_o, 1'b0);
        checkOutput("rst_fillerr", fill_err_o, 1'b0);
        idleCycle();
        rst_i = 1'b0;
        idleCycle();
        checkOutput("post_rst_inflight", inflight_cnt_o, 2'd0);

        // Basic fill: fill_ack_o lands 6 cycles after the request cycle.
        runFill("fill1", 32'h1008, EXP_ADR_1008, {WD, WC, WB, WA}, EXP_LINE_1, 1'b0);

        // Three non-cacheable requests without responses: the third is withheld.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2006, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("nc1_stb", biu_stb_o, 1'b1);
        checkOutput("nc1_burst", biu_burst_o, 1'b0);
        checkOutput("nc1_adr", biu_adri_o, 32'h2004);
        checkOutput("nc1_stbak", nc_stb_ack_o, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2006, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("nc2_stb", biu_stb_o, 1'b1);
        checkOutput("nc2_inflight", inflight_cnt_o, 2'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2006, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("nc3_stb", biu_stb_o, 1'b0);
        checkOutput("nc3_stbak", nc_stb_ack_o, 1'b0);
        checkOutput("nc3_inflight", inflight_cnt_o, 2'd2);

        // Flush with two outstanding: both responses are swallowed.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_inflight", inflight_cnt_o, 2'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77);
        checkOutput("disc1_ncack", nc_ack_o, 1'b0);
        checkOutput("disc1_inflight", inflight_cnt_o, 2'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h78);
        checkOutput("disc2_ncack", nc_ack_o, 1'b0);
        checkOutput("disc2_inflight", inflight_cnt_o, 2'd1);
        idleCycle();
        checkOutput("disc_done_inflight", inflight_cnt_o, 2'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("nc4_stb", biu_stb_o, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h99);
        checkOutput("nc4_ncack", nc_ack_o, 1'b1);
        checkOutput("nc4_inflight", inflight_cnt_o, 2'd1);
        idleCycle();
        checkOutput("nc4_done_inflight", inflight_cnt_o, 2'd0);

        // Bus error on the second beat aborts the fill.
        applyStimulus(1'b1, 32'h1008, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("err_idle_stb", biu_stb_o, 1'b0);
        applyStimulus(1'b1, 32'h1008, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("err_req_burst", biu_burst_o, 1'b1);
        applyStimulus(1'b0, 32'h1008, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hEEEE0001);
        applyStimulus(1'b0, 32'h1008, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("err_beat_fillerr", fill_err_o, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2006, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("err_pulse", fill_err_o, 1'b1);
        checkOutput("err_fillack", fill_ack_o, 1'b0);
        checkOutput("err_idle_ncstb", biu_stb_o, 1'b1);
        checkOutput("err_idle_ncburst", biu_burst_o, 1'b0);
        checkOutput("err_vld", word_vld_o, EXP_VLD_ERR);
        idleCycle();
        checkOutput("err_pulse_end", fill_err_o, 1'b0);
        checkOutput("err_no_fillack", fill_ack_o, 1'b0);
        runFill("refill", 32'h3000, 32'h3000, {WS, WR, WQ, WP}, {WS, WR, WQ, WP}, 1'b0);

        // Fill waits for the outstanding read and then has priority over non-cacheable.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("prio_nc_stb", biu_stb_o, 1'b1);
        applyStimulus(1'b1, 32'h4004, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("prio_wait1_stb", biu_stb_o, 1'b0);
        checkOutput("prio_wait1_ncstbak", nc_stb_ack_o, 1'b0);
        checkOutput("prio_wait1_inflight", inflight_cnt_o, 2'd1);
        applyStimulus(1'b1, 32'h4004, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("prio_wait2_stb", biu_stb_o, 1'b0);
        applyStimulus(1'b1, 32'h4004, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("prio_rsp_stb", biu_stb_o, 1'b0);
        checkOutput("prio_rsp_ncack", nc_ack_o, 1'b1);
        checkOutput("prio_rsp_ncstbak", nc_stb_ack_o, 1'b0);
        runFill("prio", 32'h4004, EXP_ADR_4004, {T3, T2, T1, T0}, EXP_LINE_5, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("prio_after_ncstbak", nc_stb_ack_o, 1'b1);
        checkOutput("prio_after_adr", biu_adri_o, 32'h6000);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("prio_after_ncack", nc_ack_o, 1'b1);
        idleCycle();
        checkOutput("prio_after_inflight", inflight_cnt_o, 2'd0);

        // Reset in the middle of a burst abandons the fill.
        applyStimulus(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mrst_req_stb", biu_stb_o, 1'b1);
        applyStimulus(1'b0, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFACE0001);
        rst_i = 1'b1;
        applyStimulus(1'b0, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFACE0002);
        checkOutput("mrst_stb", biu_stb_o, 1'b0);
        checkOutput("mrst_vld", word_vld_o, 4'h0);
        checkOutput("mrst_line", line_o, 128'h0);
        checkOutput("mrst_fillack", fill_ack_o, 1'b0);
        rst_i = 1'b0;
        idleCycle();
        checkOutput("mrst_after_fillack", fill_ack_o, 1'b0);
        checkOutput("mrst_after_stb", biu_stb_o, 1'b0);
        checkOutput("mrst_after_inflight", inflight_cnt_o, 2'd0);
        idleCycle();
        checkOutput("mrst_after2_fillack", fill_ack_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/riscv_cache_biu_arb.md
RISCV_CACHE_BIU_ARB -- requirements
Module: riscv_cache_biu_arb

Interface
REQ-001 Parameter XLEN, default 32, data/word width in bits (32 or 64).
REQ-002 Parameter PLEN, default XLEN, physical address width.
REQ-003 Parameter BLK_BITS, default 128, cache line width; BURST_SIZE = BLK_BITS/XLEN, a power of 2 and at least 2.
REQ-004 Parameter INFLIGHT_DEPTH, default 2, maximum outstanding BIU transfers; INFLIGHT_BITS = $clog2(INFLIGHT_DEPTH+1).
REQ-005 Port clk_i, in, 1, single clock; all logic is rising-edge.
REQ-006 Port rst_i, in, 1, reset: synchronous, active-high.
REQ-007 Ports fill_req_i (in, 1), fill_adr_i (in, PLEN), fill_ack_o (out, 1), fill_err_o (out, 1): line-fill request, miss address, line-complete pulse, fill-error pulse.
REQ-008 Ports nc_req_i (in, 1), nc_adr_i (in, PLEN), nc_stb_ack_o (out, 1), nc_ack_o (out, 1): non-cacheable single read, address, accepted, data valid.
REQ-009 Port flush_i, in, 1, pipe flush; pending non-cacheable data is discarded.
REQ-010 Ports biu_stb_o (out, 1), biu_stb_ack_i (in, 1), biu_adri_o (out, PLEN), biu_burst_o (out, 1), biu_ack_i (in, 1), biu_err_i (in, 1), biu_q_i (in, XLEN): BIU command/response.
REQ-011 Ports line_o (out, BLK_BITS), word_vld_o (out, BURST_SIZE), inflight_cnt_o (out, INFLIGHT_BITS): fill buffer, per-word valid mask, outstanding count.

Function
REQ-012 States are IDLE, FILL_REQ, FILL_DATA and FILL_DONE.
REQ-013 IDLE: when fill_req_i=1 and inflight=0, the block goes to FILL_REQ; when fill_req_i=1 and inflight>0, it holds IDLE and issues no new strobes.
REQ-014 IDLE: when nc_req_i=1, fill_req_i=0 and inflight<INFLIGHT_DEPTH, it drives biu_stb_o=1, biu_burst_o=0, biu_adri_o=nc_adr_i with bits [$clog2(XLEN/8)-1:0] cleared, and nc_stb_ack_o=biu_stb_ack_i, all combinationally.
REQ-015 Fill has priority over non-cacheable; in every state other than IDLE, nc_stb_ack_o=0.
REQ-016 inflight counts +1 on biu_stb_o&biu_stb_ack_i and -1 on biu_ack_i|biu_err_i; simultaneous increment and decrement leaves it unchanged; it never exceeds INFLIGHT_DEPTH and never underflows.
REQ-017 On flush_i, the discard counter loads (inflight + accepted strobe - response) for that cycle; each later response decrements it.
REQ-018 nc_ack_o = biu_ack_i & state==IDLE & discard==0; a response arriving while discard>0 produces no nc_ack_o.
REQ-019 FILL_REQ: drives biu_stb_o=1, biu_burst_o=1 and a start address per REQ-030; it clears word_vld_o on entry and goes to FILL_DATA on biu_stb_ack_i.
REQ-020 FILL_DATA: on each biu_ack_i, biu_q_i is written to line_o[widx*XLEN +: XLEN] and word_vld_o[widx] is set; widx then increments modulo BURST_SIZE (wrap-around).
REQ-021 FILL_DATA: when the BURST_SIZE-th beat is acked, the block goes to FILL_DONE.
REQ-022 FILL_DONE: fill_ack_o=1 for exactly one cycle, then the block returns to IDLE; line_o and word_vld_o hold until the next FILL_REQ.
REQ-023 biu_err_i in FILL_REQ or FILL_DATA pulses fill_err_o for one cycle and returns the block to IDLE without fill_ack_o; the BIU terminates the burst.
REQ-024 Deasserting fill_req_i mid-fill does not abort the burst; it completes and fill_ack_o still pulses.
REQ-025 flush_i during a fill does not affect the fill.
REQ-026 Total latency from fill_req_i to fill_ack_o is 1 + stb_ack wait + BURST_SIZE beats + 1 cycles.

Reset
REQ-027 While rst_i=1 at a clock edge: state=IDLE, inflight=0, discard=0, widx=0, word_vld_o=0, line_o=0, fill_ack_o=0, fill_err_o=0.
REQ-028 During reset, biu_stb_o=0, nc_stb_ack_o=0 and nc_ack_o=0 combinationally.
REQ-029 Reset asserted mid-burst abandons the fill with no fill_ack_o; the system resets the BIU concurrently.

Configuration
REQ-030 Macro RISCV_CACHE_ARB_CWF_EN defined: the fill start address is fill_adr_i word-aligned (critical word first), widx starts at fill_adr_i's word offset in the line, and the burst wraps. Undefined: the start address is fill_adr_i line-aligned and widx starts at 0.

Verification
REQ-031 XLEN=32, BLK_BITS=128, CWF on, fill_adr_i=0x1008, immediate stb_ack, beats A,B,C,D -> biu_adri_o=0x1008, words 2,3,0,1 = A,B,C,D, fill_ack_o pulses 6 cycles after the request.
REQ-032 Same stimulus, CWF off -> biu_adri_o=0x1000, words 0..3 = A..D.
REQ-033 nc_req_i with nc_adr_i=0x2006 issued 3 times, no acks -> 2 strobes at address 0x2004, third strobe withheld, inflight_cnt_o=2.
REQ-034 Two non-cacheable reads outstanding, flush_i, then 2 acks -> nc_ack_o stays 0 and inflight returns to 0.
REQ-035 biu_err_i on beat 2 of a fill -> fill_err_o pulses, no fill_ack_o, state IDLE; a following fill succeeds.
REQ-036 fill_req_i and nc_req_i asserted together with inflight=1 -> no strobe until the ack, then a burst strobe; nc_stb_ack_o stays 0 until FILL_DONE passes.
